// File: rtl/move_cmd_arbiter.sv
// Move command arbiter: merges button pulses, UART command bytes and the turn
// timeout into paced single-cycle move pulses for the connect-4 game FSM, and
// owns the per-turn seconds countdown.
module move_cmd_arbiter #(
  parameter int unsigned TICKS_PER_SEC = 25000000,
  parameter int unsigned TURN_SECONDS  = 10,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  input  logic       turn_active,
  input  logic       player_turn,
  output logic       move_left,
  output logic       move_right,
  output logic       move_made,
  output logic [3:0] seconds_left,
  output logic       timeout_flag,
  output logic       cmd_dropped
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LEFT  = 2'd1;
  localparam logic [1:0] CMD_RIGHT = 2'd2;
  localparam logic [1:0] CMD_DROP  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Registered state
  logic [1:0]        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        secs_q;
  logic              move_left_q, move_right_q, move_made_q;
  logic              timeout_q, dropped_q;
  logic              turn_active_q, player_turn_q;

  // Next-state / control
  logic [1:0]        uart_cmd;
  logic [2:0]        n_req;
  logic              any_req, multi_req;
  logic [1:0]        win_cmd;
  logic              fifo_empty, fifo_full, gap_done;
  logic              pop, push, flush_to;
  logic              fifo_we;
  logic [PTR_W-1:0]  fifo_waddr;
  logic [1:0]        fifo_wdata;
  logic [1:0]        head_cmd;
  logic [1:0]        state_d;
  logic [GAP_W-1:0]  gap_d;
  logic              move_left_d, move_right_d, move_made_d;
  logic              dropped_d;
  logic              reload;
  logic [3:0]        secs_d;
  logic [TICK_W-1:0] tick_d;
  logic              timeout_d;

  // UART byte decode; unknown bytes are not requests at all
  always_comb begin
    uart_cmd = CMD_NONE;
    if (uart_valid) begin
      case (uart_data)
        8'h01:   uart_cmd = CMD_RIGHT;
        8'h02:   uart_cmd = CMD_LEFT;
        8'h03:   uart_cmd = CMD_DROP;
        default: uart_cmd = CMD_NONE;
      endcase
    end
  end

  // Request arbitration, FIFO control and drop reporting
  always_comb begin
    n_req = 3'(timeout_q) + 3'(btn_drop) + 3'(btn_left) + 3'(btn_right)
          + 3'(uart_cmd != CMD_NONE);
    any_req   = (n_req != 3'd0);
    multi_req = (n_req > 3'd1);

    win_cmd = uart_cmd;
    if (timeout_q || btn_drop) win_cmd = CMD_DROP;
    else if (btn_left)         win_cmd = CMD_LEFT;
    else if (btn_right)        win_cmd = CMD_RIGHT;

    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    gap_done   = (state == S_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    head_cmd   = fifo_mem[rd_ptr];

    // A timeout replaces the whole queue with one DROP, so nothing pops that cycle
    flush_to = turn_active && timeout_q;
    pop      = turn_active && !timeout_q && !fifo_empty && ((state == S_IDLE) || gap_done);
    push     = turn_active && !timeout_q && any_req && (!fifo_full || pop);

    fifo_we    = push || flush_to;
    fifo_waddr = flush_to ? '0 : wr_ptr;
    fifo_wdata = flush_to ? CMD_DROP : win_cmd;

    if (turn_active) dropped_d = multi_req || (any_req && !timeout_q && !push);
    else             dropped_d = any_req;
  end

  // Issue FSM next state; the final gap cycle doubles as the pop decision
  always_comb begin
    state_d      = state;
    gap_d        = gap_cnt;
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    move_made_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_done) state_d = pop ? S_ISSUE : S_IDLE;
        else          gap_d   = gap_cnt + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      move_left_d  = (head_cmd == CMD_LEFT);
      move_right_d = (head_cmd == CMD_RIGHT);
      move_made_d  = (head_cmd == CMD_DROP);
    end
    if (!turn_active) state_d = S_IDLE;
  end

  // Turn countdown: reload wins over decrement, timeout fires on reaching zero
  always_comb begin
    reload    = move_made_q || (player_turn != player_turn_q) || (turn_active && !turn_active_q);
    secs_d    = secs_q;
    tick_d    = tick_cnt;
    timeout_d = 1'b0;
    if (reload) begin
      secs_d = 4'(TURN_SECONDS);
      tick_d = '0;
    end else if (turn_active && (secs_q != 4'd0)) begin
      if (tick_cnt == TICK_W'(TICKS_PER_SEC - 1)) begin
        tick_d    = '0;
        secs_d    = secs_q - 4'd1;
        timeout_d = (secs_q == 4'd1);
      end else begin
        tick_d = tick_cnt + TICK_W'(1);
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      move_left_q   <= 1'b0;
      move_right_q  <= 1'b0;
      move_made_q   <= 1'b0;
      timeout_q     <= 1'b0;
      dropped_q     <= 1'b0;
      secs_q        <= 4'(TURN_SECONDS);
      tick_cnt      <= '0;
      turn_active_q <= 1'b0;
      player_turn_q <= 1'b0;
    end else begin
      state         <= state_d;
      gap_cnt       <= gap_d;
      move_left_q   <= move_left_d;
      move_right_q  <= move_right_d;
      move_made_q   <= move_made_d;
      timeout_q     <= timeout_d;
      dropped_q     <= dropped_d;
      secs_q        <= secs_d;
      tick_cnt      <= tick_d;
      turn_active_q <= turn_active;
      player_turn_q <= player_turn;
    end
  end

  // FIFO pointers; inactive turn or timeout discards queued entries
  always_ff @(posedge clk) begin
    if (reset || !turn_active) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_to) begin
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(1);
      count  <= CNT_W'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[fifo_waddr] <= fifo_wdata;
  end

  // Reset cuts any pulse already on the outputs in the reset cycle itself
  assign move_left    = move_left_q  & ~reset;
  assign move_right   = move_right_q & ~reset;
  assign move_made    = move_made_q  & ~reset;
  assign timeout_flag = timeout_q    & ~reset;
  assign cmd_dropped  = dropped_q    & ~reset;
  assign seconds_left = reset ? 4'(TURN_SECONDS) : secs_q;

endmodule
